// File: rtl/snoop_req_handler.sv
// Snoop request sequencer for a direct-mapped MESI cache: looks up the snooped line,
// applies the bus-side MESI transition, writes back dirty data and answers the bus.
package snoop_pkg;
  localparam logic [1:0] BUS_NO_REQ          = 2'd0;
  localparam logic [1:0] BUS_READ_REQ        = 2'd1;
  localparam logic [1:0] BUS_INVALIDATE_REQ  = 2'd2;
  localparam logic [1:0] BUS_RWITM_REQ       = 2'd3;
  localparam logic [1:0] BUS_NO_RSP          = 2'd0;
  localparam logic [1:0] BUS_SNOOP_FOUND_RSP = 2'd1;
  localparam logic [3:0] INVALID             = 4'd0;
  localparam logic [3:0] SHARED              = 4'd1;
  localparam logic [3:0] EXCLUSIVE           = 4'd2;
  localparam logic [3:0] MODIFIED            = 4'd3;
endpackage

module fsm_bus_req_ctrl
  import snoop_pkg::*;
(
  input  logic [3:0] cur_state_i,
  input  logic [1:0] bus_req_i,
  output logic [3:0] nxt_state_o,
  output logic       write_back_o,
  output logic       send_bus_rsp_o
);
  logic line_valid;
  assign line_valid = cur_state_i inside {SHARED, EXCLUSIVE, MODIFIED};

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    nxt_state_o    = cur_state_i;
    write_back_o   = 1'b0;
    send_bus_rsp_o = 1'b0;
    case (bus_req_i)
      BUS_READ_REQ: if (line_valid) begin
        nxt_state_o    = SHARED;
        write_back_o   = (cur_state_i == MODIFIED);
        send_bus_rsp_o = 1'b1;
      end
      BUS_RWITM_REQ: if (line_valid) begin
        nxt_state_o    = INVALID;
        write_back_o   = (cur_state_i == MODIFIED);
        send_bus_rsp_o = 1'b1;
      end
      BUS_INVALIDATE_REQ: if (cur_state_i == SHARED) nxt_state_o = INVALID;
      default: ;
    endcase
  end
endmodule

module snoop_req_handler
  import snoop_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bus_req_valid,
  input  logic [1:0]              bus_req,
  input  logic [ADDR_W-1:0]       bus_addr,
  output logic                    bus_req_ready,
  output logic                    bus_rsp_valid,
  output logic [1:0]              bus_rsp,
  output logic                    arr_rd_en,
  output logic [IDX_W-1:0]        arr_idx,
  input  logic [ADDR_W-IDX_W-1:0] arr_rd_tag,
  input  logic [3:0]              arr_rd_state,
  input  logic [DATA_W-1:0]       arr_rd_data,
  output logic                    arr_st_wr_en,
  output logic [3:0]              arr_st_wr_state,
  output logic                    mem_wb_valid,
  output logic [ADDR_W-1:0]       mem_wb_addr,
  output logic [DATA_W-1:0]       mem_wb_data,
  input  logic                    mem_wb_ready,
  output logic                    busy,
  output logic                    protocol_err,
  output logic [15:0]             stat_hit_cnt,
  output logic [15:0]             stat_wb_cnt
);
  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_DECIDE, S_WB, S_UPDATE, S_RSP
  } fsm_e;

  fsm_e              state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        req_q;
  logic [DATA_W-1:0] data_q;
  logic [3:0]        nxt_q;
  logic [1:0]        rsp_q;
  logic [15:0]       hit_cnt_q, hit_cnt_d;
  logic [15:0]       wb_cnt_q, wb_cnt_d;

  logic       accept, hit, illegal, hit_ok;
  logic [3:0] ctrl_nxt;
  logic       ctrl_wb, ctrl_rsp;

  assign accept  = bus_req_valid && (bus_req != BUS_NO_REQ);
  assign hit     = (arr_rd_tag == addr_q[ADDR_W-1:IDX_W])
                   && (arr_rd_state inside {SHARED, EXCLUSIVE, MODIFIED});
  // Invalidate only makes sense against a shared copy; another owner means a broken peer.
  assign illegal = hit && (req_q == BUS_INVALIDATE_REQ)
                   && (arr_rd_state inside {EXCLUSIVE, MODIFIED});
  assign hit_ok  = hit && !illegal;

  fsm_bus_req_ctrl u_ctrl (
    .cur_state_i    (arr_rd_state),
    .bus_req_i      (req_q),
    .nxt_state_o    (ctrl_nxt),
    .write_back_o   (ctrl_wb),
    .send_bus_rsp_o (ctrl_rsp)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_LOOKUP;
      S_LOOKUP: state_d = S_DECIDE;
      S_DECIDE: begin
        if (!hit_ok)      state_d = S_RSP;
        else if (ctrl_wb) state_d = S_WB;
        else              state_d = S_UPDATE;
      end
      S_WB:     if (mem_wb_ready) state_d = S_UPDATE;
      S_UPDATE: state_d = S_RSP;
      S_RSP:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus_req_ready = 1'b0;
    arr_rd_en     = 1'b0;
    protocol_err  = 1'b0;
    mem_wb_valid  = 1'b0;
    arr_st_wr_en  = 1'b0;
    bus_rsp_valid = 1'b0;
    case (state_q)
      S_IDLE:   bus_req_ready = 1'b1;
      S_LOOKUP: arr_rd_en     = 1'b1;
      S_DECIDE: protocol_err  = illegal;
      S_WB:     mem_wb_valid  = 1'b1;
      S_UPDATE: arr_st_wr_en  = 1'b1;
      S_RSP:    bus_rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      req_q  <= BUS_NO_REQ;
      data_q <= '0;
      nxt_q  <= INVALID;
      rsp_q  <= BUS_NO_RSP;
    end else begin
      if (state_q == S_IDLE && accept) begin
        addr_q <= bus_addr;
        req_q  <= bus_req;
      end
      if (state_q == S_DECIDE) begin
        rsp_q <= (hit_ok && ctrl_rsp) ? BUS_SNOOP_FOUND_RSP : BUS_NO_RSP;
        if (hit_ok) begin
          nxt_q  <= ctrl_nxt;
          data_q <= arr_rd_data;
        end
      end
    end
  end

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    wb_cnt_d  = wb_cnt_q;
    if (state_q == S_DECIDE && hit_ok && hit_cnt_q != 16'hFFFF)
      hit_cnt_d = hit_cnt_q + 16'd1;
    if (state_q == S_WB && mem_wb_ready && wb_cnt_q != 16'hFFFF)
      wb_cnt_d = wb_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q <= '0;
      wb_cnt_q  <= '0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
      wb_cnt_q  <= wb_cnt_d;
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign bus_rsp         = bus_rsp_valid ? rsp_q : BUS_NO_RSP;
  assign arr_idx         = addr_q[IDX_W-1:0];
  assign arr_st_wr_state = nxt_q;
  assign mem_wb_addr     = addr_q;
  assign mem_wb_data     = data_q;
  assign stat_hit_cnt    = hit_cnt_q;
  assign stat_wb_cnt     = wb_cnt_q;
endmodule

// File: tb/tb_snoop_req_handler.sv
// Directed bench for snoop_req_handler: a cache-array model feeds the DUT and every
// transaction is checked cycle by cycle against a timeline derived from MESI rules.
module tb_snoop_req_handler;
  import snoop_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 4;
  localparam int TAG_W  = ADDR_W - IDX_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              bus_req_valid;
  logic [1:0]        bus_req;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_req_ready, bus_rsp_valid;
  logic [1:0]        bus_rsp;
  logic              arr_rd_en;
  logic [IDX_W-1:0]  arr_idx;
  logic [TAG_W-1:0]  arr_rd_tag = '0;
  logic [3:0]        arr_rd_state = '0;
  logic [DATA_W-1:0] arr_rd_data = '0;
  logic              arr_st_wr_en;
  logic [3:0]        arr_st_wr_state;
  logic              mem_wb_valid;
  logic [ADDR_W-1:0] mem_wb_addr;
  logic [DATA_W-1:0] mem_wb_data;
  logic              mem_wb_ready;
  logic              busy, protocol_err;
  logic [15:0]       stat_hit_cnt, stat_wb_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_hits = 0;
  int exp_wbs  = 0;

  always #5 clk = ~clk;

  snoop_req_handler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus_req_valid   (bus_req_valid),
    .bus_req         (bus_req),
    .bus_addr        (bus_addr),
    .bus_req_ready   (bus_req_ready),
    .bus_rsp_valid   (bus_rsp_valid),
    .bus_rsp         (bus_rsp),
    .arr_rd_en       (arr_rd_en),
    .arr_idx         (arr_idx),
    .arr_rd_tag      (arr_rd_tag),
    .arr_rd_state    (arr_rd_state),
    .arr_rd_data     (arr_rd_data),
    .arr_st_wr_en    (arr_st_wr_en),
    .arr_st_wr_state (arr_st_wr_state),
    .mem_wb_valid    (mem_wb_valid),
    .mem_wb_addr     (mem_wb_addr),
    .mem_wb_data     (mem_wb_data),
    .mem_wb_ready    (mem_wb_ready),
    .busy            (busy),
    .protocol_err    (protocol_err),
    .stat_hit_cnt    (stat_hit_cnt),
    .stat_wb_cnt     (stat_wb_cnt)
  );

  // Cache array model: registered read port, state write port and a preload channel.
  logic [TAG_W-1:0]  tag_mem  [16];
  logic [3:0]        st_mem   [16];
  logic [DATA_W-1:0] data_mem [16];
  logic              ld_en = 1'b0;
  logic [3:0]        ld_idx = '0;
  logic [TAG_W-1:0]  ld_tag = '0;
  logic [3:0]        ld_st = '0;
  logic [DATA_W-1:0] ld_data = '0;

  always @(posedge clk) begin
    if (ld_en) begin
      tag_mem[ld_idx]  <= ld_tag;
      st_mem[ld_idx]   <= ld_st;
      data_mem[ld_idx] <= ld_data;
    end
    if (arr_rd_en) begin
      arr_rd_tag   <= tag_mem[arr_idx];
      arr_rd_state <= st_mem[arr_idx];
      arr_rd_data  <= data_mem[arr_idx];
    end
    if (arr_st_wr_en) st_mem[arr_idx] <= arr_st_wr_state;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // MESI bus-side rules: what a snoop must do to a line, independent of any sequencing.
  function automatic void predict(input logic [1:0] req, input logic [3:0] st, input bit tag_eq,
                                  output bit hit, output bit illegal, output bit wb,
                                  output bit found, output logic [3:0] nxt);
    hit     = tag_eq && (st == SHARED || st == EXCLUSIVE || st == MODIFIED);
    illegal = hit && req == BUS_INVALIDATE_REQ && st != SHARED;
    wb      = 1'b0;
    found   = 1'b0;
    nxt     = st;
    if (hit && !illegal) begin
      nxt   = (req == BUS_READ_REQ) ? SHARED : INVALID;
      wb    = (st == MODIFIED) && req != BUS_INVALIDATE_REQ;
      found = (req != BUS_INVALIDATE_REQ);
    end
  endfunction

  task automatic load_line(input int idx, input logic [TAG_W-1:0] tag, input logic [3:0] st,
                           input logic [DATA_W-1:0] data);
    ld_en = 1'b1; ld_idx = 4'(idx); ld_tag = tag; ld_st = st; ld_data = data;
    @(posedge clk);
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Starts and ends on a falling edge with the DUT idle. With hold set, the next request
  // is presented right after acceptance and kept on the bus until the following call.
  task automatic run_snoop(input logic [1:0] req, input logic [ADDR_W-1:0] addr,
                           input int wb_delay, input bit hold,
                           input logic [1:0] nreq, input logic [ADDR_W-1:0] naddr);
    int idx, wb_end, upd_k, rsp_k;
    bit hit, illegal, wb, found, upd;
    logic [3:0] nxt;
    logic [DATA_W-1:0] exp_data;
    logic [6:0] act_v, exp_v;
    idx = int'(addr[IDX_W-1:0]);
    predict(req, st_mem[idx], tag_mem[idx] == addr[ADDR_W-1:IDX_W], hit, illegal, wb, found, nxt);
    exp_data = data_mem[idx];
    upd    = hit && !illegal;
    wb_end = wb ? 3 + wb_delay : 2;
    upd_k  = wb_end + 1;
    rsp_k  = upd ? upd_k + 1 : 3;

    bus_req_valid = 1'b1; bus_req = req; bus_addr = addr;
    check("ready_before_accept", bus_req_ready, 1'b1);
    @(posedge clk);
    for (int k = 1; k <= rsp_k + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (hold) begin
          bus_req = nreq; bus_addr = naddr;
        end else begin
          bus_req_valid = 1'b0; bus_req = BUS_NO_REQ; bus_addr = '0;
        end
      end
      act_v = {busy, bus_req_ready, arr_rd_en, protocol_err, mem_wb_valid, arr_st_wr_en,
               bus_rsp_valid};
      exp_v = {k <= rsp_k, k > rsp_k, k == 1, illegal && k == 2, wb && k >= 3 && k <= wb_end,
               upd && k == upd_k, k == rsp_k};
      check($sformatf("strobes_k%0d", k), act_v, exp_v);
      if (k == 1) check("rd_idx", arr_idx, idx);
      if (wb && k >= 3 && k <= wb_end) begin
        check("wb_addr", mem_wb_addr, addr);
        check("wb_data", mem_wb_data, exp_data);
      end
      if (upd && k == upd_k) begin
        check("wr_state", arr_st_wr_state, nxt);
        check("wr_idx", arr_idx, idx);
      end
      if (k == rsp_k) check("rsp", bus_rsp, found ? BUS_SNOOP_FOUND_RSP : BUS_NO_RSP);
      mem_wb_ready = wb && (k == wb_end);
    end
    if (upd && exp_hits < 65535) exp_hits++;
    if (wb && exp_wbs < 65535) exp_wbs++;
    check("hit_cnt", stat_hit_cnt, exp_hits);
    check("wb_cnt", stat_wb_cnt, exp_wbs);
  endtask

  initial begin
    rst = 1'b1; bus_req_valid = 1'b0; bus_req = BUS_NO_REQ; bus_addr = '0; mem_wb_ready = 1'b0;
    @(negedge clk);
    check("rst_strobes", {busy, arr_rd_en, protocol_err, mem_wb_valid, arr_st_wr_en, bus_rsp_valid},
          6'b0);
    check("rst_rsp", bus_rsp, 2'b0);
    check("rst_hit_cnt", stat_hit_cnt, 16'd0);
    check("rst_wb_cnt", stat_wb_cnt, 16'd0);
    check("rst_regs", {mem_wb_addr, mem_wb_data}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", {busy, bus_req_ready}, 2'b01);

    load_line(1, 28'h1234567, EXCLUSIVE, 32'h11110001);
    load_line(2, 28'hABCDEF0, MODIFIED,  32'hDEADBEEF);
    load_line(3, 28'h0000003, SHARED,    32'h33330003);
    load_line(4, 28'h0000044, SHARED,    32'h44440004);
    load_line(5, 28'h0000055, MODIFIED,  32'h55550005);
    load_line(6, 28'h0000066, MODIFIED,  32'h66660006);
    load_line(7, 28'h0000077, EXCLUSIVE, 32'h77770007);
    load_line(8, 28'h0000088, INVALID,   32'h88880008);
    load_line(9, 28'h0BADC0D, MODIFIED,  32'h99990009);

    // Read hit on EXCLUSIVE: becomes SHARED, found, no write-back.
    run_snoop(BUS_READ_REQ, {28'h1234567, 4'd1}, 0, 1'b0, BUS_NO_REQ, '0);
    check("pin_e_to_s", st_mem[1], SHARED);
    check("pin_hit_one", stat_hit_cnt, 16'd1);

    // RWITM on MODIFIED with memory stalling three cycles.
    run_snoop(BUS_RWITM_REQ, {28'hABCDEF0, 4'd2}, 3, 1'b0, BUS_NO_REQ, '0);
    check("pin_m_to_i", st_mem[2], INVALID);
    check("pin_wb_one", stat_wb_cnt, 16'd1);

    // Tag mismatch, then a matching tag on an INVALID line: both are misses.
    run_snoop(BUS_READ_REQ, {28'h0000999, 4'd3}, 0, 1'b0, BUS_NO_REQ, '0);
    check("pin_miss_kept", st_mem[3], SHARED);
    run_snoop(BUS_READ_REQ, {28'h0000088, 4'd8}, 0, 1'b0, BUS_NO_REQ, '0);

    // Invalidate on SHARED is legal; on MODIFIED it is a protocol error.
    run_snoop(BUS_INVALIDATE_REQ, {28'h0000044, 4'd4}, 0, 1'b0, BUS_NO_REQ, '0);
    check("pin_inv_s", st_mem[4], INVALID);
    run_snoop(BUS_INVALIDATE_REQ, {28'h0000055, 4'd5}, 0, 1'b0, BUS_NO_REQ, '0);
    check("pin_inv_m_kept", st_mem[5], MODIFIED);
    check("pin_hit_three", stat_hit_cnt, 16'd3);

    // A valid BUS_NO_REQ is swallowed without leaving IDLE.
    bus_req_valid = 1'b1; bus_req = BUS_NO_REQ; bus_addr = {28'h1234567, 4'd1};
    @(negedge clk);
    check("noreq_idle", {busy, bus_req_ready}, 2'b01);
    bus_req_valid = 1'b0; bus_addr = '0;
    @(negedge clk);
    check("noreq_still_idle", {busy, bus_req_ready}, 2'b01);

    // Read on MODIFIED with memory ready at once, second request held on the bus meanwhile.
    run_snoop(BUS_READ_REQ, {28'h0000066, 4'd6}, 0, 1'b1, BUS_READ_REQ, {28'h0000077, 4'd7});
    run_snoop(BUS_READ_REQ, {28'h0000077, 4'd7}, 0, 1'b0, BUS_NO_REQ, '0);
    check("pin_bp_first", st_mem[6], SHARED);
    check("pin_bp_second", st_mem[7], SHARED);
    check("pin_wb_two", stat_wb_cnt, 16'd2);

    // Reset while the write-back is stalled.
    bus_req_valid = 1'b1; bus_req = BUS_RWITM_REQ; bus_addr = {28'h0BADC0D, 4'd9};
    @(posedge clk);
    @(negedge clk);
    bus_req_valid = 1'b0; bus_req = BUS_NO_REQ; bus_addr = '0;
    repeat (3) @(negedge clk);
    check("pre_rst_in_wb", mem_wb_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_strobes",
          {busy, arr_rd_en, protocol_err, mem_wb_valid, arr_st_wr_en, bus_rsp_valid}, 6'b0);
    check("midrst_cnts", {stat_hit_cnt, stat_wb_cnt}, 32'd0);
    check("midrst_addr", mem_wb_addr, 32'd0);
    @(negedge clk);
    check("midrst_held",
          {busy, arr_rd_en, protocol_err, mem_wb_valid, arr_st_wr_en, bus_rsp_valid}, 6'b0);
    rst = 1'b0;
    exp_hits = 0;
    exp_wbs  = 0;
    @(negedge clk);
    check("post_rst_idle", {busy, bus_req_ready}, 2'b01);
    check("pin_rst_no_write", st_mem[9], MODIFIED);

    // Hit counter saturation, starting from a preloaded 16'hFFFE.
    force dut.hit_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.hit_cnt_q;
    @(negedge clk);
    check("sat_preload", stat_hit_cnt, 16'hFFFE);
    exp_hits = 65534;
    run_snoop(BUS_READ_REQ, {28'h1234567, 4'd1}, 0, 1'b0, BUS_NO_REQ, '0);
    run_snoop(BUS_READ_REQ, {28'h1234567, 4'd1}, 0, 1'b0, BUS_NO_REQ, '0);
    check("pin_sat", stat_hit_cnt, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
